// File: rtl/key_conditioner_if.sv
// Key conditioner bundle: raw pins in, clean levels and pulses out.
// slave = conditioner side, master = consumer driving the pins.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  localparam int FPW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              any_press;
  logic [FPW-1:0]    first_press;

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output any_press,
    output first_press
  );

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  any_press,
    input  first_press
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-FF synchronizer and debounce FSM.
// Emits a held level plus one-cycle press/release pulses.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  key_conditioner_if.slave kif
);
  localparam int FPW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  state_t            st  [N_KEYS];
  logic [CW-1:0]     cnt [N_KEYS];
  logic [N_KEYS-1:0] p;
  logic [N_KEYS-1:0] m;
  logic [N_KEYS-1:0] s;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;
  logic [FPW-1:0]    fp;

  assign p = (ACTIVE_LOW != 0) ? ~kif.key_raw : kif.key_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      m     <= '0;
      s     <= '0;
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      m     <= p;
      s     <= m;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        unique case (st[i])
          IDLE: begin
            if (s[i]) begin
              st[i]  <= PRESS_WAIT;
              cnt[i] <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!s[i]) begin
              st[i]  <= IDLE;
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              st[i]    <= HELD;
              cnt[i]   <= '0;
              press[i] <= 1'b1;
              level[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          HELD: begin
            if (!s[i]) begin
              st[i]  <= REL_WAIT;
              cnt[i] <= '0;
            end
          end
          REL_WAIT: begin
            if (s[i]) begin
              st[i]  <= HELD;
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              st[i]    <= IDLE;
              cnt[i]   <= '0;
              rel[i]   <= 1'b1;
              level[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        endcase
      end
    end
  end

  // Scan high to low so the lowest pressed index wins.
  always_comb begin
    fp = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press[i]) fp = FPW'(i);
    end
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = rel;
  assign kif.any_press   = |press;
  assign kif.first_press = fp;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner.
// DUT a: active-low, 4-cycle debounce; DUT b: active-high, 2-cycle.
module tb_key_conditioner;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  key_conditioner_if #(.N_KEYS(4)) ka ();
  key_conditioner_if #(.N_KEYS(4)) kb ();

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .kif  (ka)
  );

  key_conditioner #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(2),
    .ACTIVE_LOW(0)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .kif  (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet_a(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, 32'(ka.key_press), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    ka.key_raw = 4'b1111;
    kb.key_raw = 4'b0000;
    step(3);
    check("rst_level", 32'(ka.key_level), 32'h0);
    check("rst_press", 32'(ka.key_press), 32'h0);
    check("rst_rel",   32'(ka.key_release), 32'h0);
    check("rst_any",   32'(ka.any_press), 32'h0);
    check("rst_first", 32'(ka.first_press), 32'h0);
    reset = 1'b0;
    step(3);

    // 1: clean press, pulse after E0+6
    ka.key_raw = 4'b1110;
    quiet_a(6, "t1_early");
    step(1);
    check("t1_press", 32'(ka.key_press), 32'h1);
    check("t1_level", 32'(ka.key_level), 32'h1);
    check("t1_any",   32'(ka.any_press), 32'h1);
    check("t1_first", 32'(ka.first_press), 32'h0);
    step(1);
    check("t1_one",   32'(ka.key_press), 32'h0);
    check("t1_hold",  32'(ka.key_level), 32'h1);

    // 3: hold without re-pulse, then release
    quiet_a(10, "t3_hold");
    ka.key_raw = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_early", 32'(ka.key_release), 32'h0);
    end
    check("t3_lvl_pre", 32'(ka.key_level), 32'h1);
    step(1);
    check("t3_rel",   32'(ka.key_release), 32'h1);
    check("t3_level", 32'(ka.key_level), 32'h0);
    check("t3_nopr",  32'(ka.key_press), 32'h0);
    step(1);
    check("t3_one",   32'(ka.key_release), 32'h0);
    step(4);

    // 2: bounce low x3, high x1, then steady low
    ka.key_raw = 4'b1110;
    quiet_a(3, "t2_bnc");
    ka.key_raw = 4'b1111;
    quiet_a(1, "t2_bnc");
    ka.key_raw = 4'b1110;
    quiet_a(6, "t2_early");
    step(1);
    check("t2_press", 32'(ka.key_press), 32'h1);
    check("t2_level", 32'(ka.key_level), 32'h1);
    ka.key_raw = 4'b1111;
    step(10);
    check("t2_idle", 32'(ka.key_level), 32'h0);

    // 4: keys 1 and 3 together
    ka.key_raw = 4'b0101;
    quiet_a(6, "t4_early");
    step(1);
    check("t4_press", 32'(ka.key_press), 32'ha);
    check("t4_any",   32'(ka.any_press), 32'h1);
    check("t4_first", 32'(ka.first_press), 32'h1);
    check("t4_level", 32'(ka.key_level), 32'ha);
    ka.key_raw = 4'b1111;
    step(10);
    check("t4_idle", 32'(ka.key_level), 32'h0);

    // 5: reset with key 0 held and key 2 mid-debounce
    ka.key_raw = 4'b1110;
    step(8);
    check("t5_held", 32'(ka.key_level), 32'h1);
    ka.key_raw = 4'b1010;
    step(5);
    check("t5_pre", 32'(ka.key_level), 32'h1);
    reset = 1'b1;
    step(1);
    check("t5_level", 32'(ka.key_level), 32'h0);
    check("t5_press", 32'(ka.key_press), 32'h0);
    check("t5_rel",   32'(ka.key_release), 32'h0);
    check("t5_any",   32'(ka.any_press), 32'h0);
    reset = 1'b0;
    ka.key_raw = 4'b1110;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_norel", 32'(ka.key_release), 32'h0);
      check("t5_early", 32'(ka.key_press), 32'h0);
    end
    step(1);
    check("t5_press2", 32'(ka.key_press), 32'h1);
    check("t5_level2", 32'(ka.key_level), 32'h1);
    ka.key_raw = 4'b1111;
    step(10);

    // 6: active-high, 2-cycle debounce
    kb.key_raw = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_early", 32'(kb.key_press), 32'h0);
    end
    step(1);
    check("t6_press", 32'(kb.key_press), 32'h1);
    check("t6_level", 32'(kb.key_level), 32'h1);
    kb.key_raw = 4'b0000;
    step(4);
    check("t6_relpre", 32'(kb.key_release), 32'h0);
    step(1);
    check("t6_rel",   32'(kb.key_release), 32'h1);
    check("t6_lvl0",  32'(kb.key_level), 32'h0);
    step(3);
    kb.key_raw = 4'b0001;
    step(1);
    kb.key_raw = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_glitch", 32'(kb.key_press), 32'h0);
      check("t6_glvl",   32'(kb.key_level), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
